bf_pair_feeder: RTL and testbench
=================================

// Module: bf_pair_feeder
// PURPOSE
//   Upstream operand sequencer for the combinational radix-2 Butterfly stage.
//   Collects one block of N complex samples from a valid/ready stream.
//   Then issues the N/2 stride-N/2 operand pairs (x[k], x[k+N/2]), one pair per
//   accepted handshake, on registered A/B buses wired to the Butterfly inputs.
//   Operates in fill-then-drain mode: a single buffer, with no overlap between
//   filling and draining.
// PARAMETERS
//   W      12  bits per real/imag component; sample = {re[2W-1:W], im[W-1:0]}
//   N      16  block length; power of two, N >= 4
//   LOG2N  4   log2(N); must match N
// PORTS
//   clk        in   1        rising-edge clock
//   rst        in   1        synchronous, active-high reset
//   in_data    in   2W       complex input sample {re, im}
//   in_valid   in   1        in_data valid
//   in_ready   out  1        feeder accepts in_data this cycle
//   out_a      out  2W       butterfly operand A = x[k]
//   out_b      out  2W       butterfly operand B = x[k+N/2]
//   out_idx    out  LOG2N-1  pair index k, 0..N/2-1
//   out_last   out  1        high with the pair k = N/2-1
//   out_valid  out  1        out_a/out_b/out_idx/out_last valid
//   out_ready  in   1        consumer takes the current pair this cycle
// BEHAVIOUR
//   Storage and handshakes
//   - Storage: N x 2W buffer; write pointer wr_cnt[LOG2N-1:0]; pair counter rd_cnt[LOG2N-2:0].
//   - Input accept = in_valid & in_ready. Output accept = out_valid & out_ready.
//   States
//   - FILL: in_ready = 1, out_valid = 0.
//       Each input accept writes buf[wr_cnt] and increments wr_cnt.
//       The accept with wr_cnt == N-1 moves to DRAIN and sets wr_cnt to 0.
//   - DRAIN: in_ready = 0.
//       out_a = buf[rd_cnt], out_b = buf[rd_cnt+N/2], out_idx = rd_cnt,
//       out_last = (rd_cnt == N/2-1).
//       Each output accept increments rd_cnt.
//       The accept with out_last = 1 returns to FILL and sets rd_cnt to 0.
//   Timing
//   - in_ready and out_valid are decoded from the state register only; they do not
//     depend on in_valid or out_ready combinationally.
//   - Latency: last input accepted in cycle t; pair 0 is valid in cycle t+1.
//     Each further pair follows 1 cycle after the previous output accept.
//     in_ready rises the cycle after the last pair is accepted.
//   - Output stall: while out_valid = 1 and out_ready = 0, every output is held
//     bit-stable.
//   - Outputs are registered. The outputs are updated on each state or counter change so
//     that the pair tracks rd_cnt with no extra cycle.
//   Data handling
//   - No arithmetic: samples pass through unmodified, and component order is preserved.
//   Boundary conditions
//   - in_valid during DRAIN is ignored and in_data is not stored.
//   - Idle gaps (in_valid = 0) in FILL do not advance wr_cnt.
//   - Reset value of every output: out_a = 0, out_b = 0, out_idx = 0, out_last = 0,
//     out_valid = 0, in_ready = 1 (state FILL).
//   - rst asserted mid-FILL or mid-DRAIN: the partial block is discarded, the counters
//     go to 0, and the state goes to FILL. Buffer contents are don't-care.
//   - The final output accept and in_valid = 1 in the same cycle: the input is not
//     accepted, because in_ready is still 0 in that cycle.
// TESTING
//   Input pattern: x[k] = {k[11:0], -k[11:0]}, so x[3] = 24'h003FFD and x[11] = 24'h00BFF5.
//   1 Stream x[0..15] back-to-back with out_ready = 1
//     -> pairs k = 0..7 on 8 consecutive cycles, starting 1 cycle after x[15].
//     -> pair 3 = (24'h003FFD, 24'h00BFF5); out_last only with k = 7.
//   2 Hold out_ready = 0 for 5 cycles at pair 2
//     -> out_a = 24'h002FFE, out_b = 24'h00AFF6, out_idx = 2 held stable all 5 cycles.
//   3 Drive in_valid = 1 continuously with changing data through DRAIN
//     -> in_ready = 0, data not stored; the next block starts with the sample
//        presented in the first cycle that in_ready = 1.
//   4 Insert random in_valid gaps in FILL
//     -> same pair sequence as scenario 1; out_valid never rises before the 16th accept.
//   5 Assert rst for 1 cycle after 9 samples, then send a fresh 16-sample block
//     -> every output is at its reset value; the first pair comes from the fresh block only.
//   6 Connect out_a/out_b to the Butterfly and run 64 random blocks
//     -> C1 and C2 match the golden x[k] +/- x[k+N/2] for every pair; error count 0.

Source files
------------

// File: rtl/bf_pair_feeder.sv
// Fill-then-drain operand sequencer for a radix-2 butterfly: buffers one block of N
// complex samples, then presents the stride-N/2 pairs (x[k], x[k+N/2]) on registered buses.
module bf_pair_feeder #(
    parameter int W     = 12,
    parameter int N     = 16,
    parameter int LOG2N = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2*W-1:0]     in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [2*W-1:0]     out_a,
    output logic [2*W-1:0]     out_b,
    output logic [LOG2N-2:0]   out_idx,
    output logic               out_last,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int HALF = N / 2;
    localparam logic [LOG2N-1:0] WR_LAST  = LOG2N'(N - 1);
    localparam logic [LOG2N-2:0] RD_LAST  = (LOG2N-1)'(HALF - 1);
    localparam logic [LOG2N-1:0] IDX_ZERO = '0;
    localparam logic [LOG2N-1:0] IDX_HALF = LOG2N'(HALF);

    typedef enum logic {
        S_FILL  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [LOG2N-1:0]   wr_cnt_q, wr_cnt_d;
    logic [LOG2N-2:0]   rd_cnt_q, rd_cnt_d;
    logic [LOG2N-2:0]   rd_nxt;
    logic [2*W-1:0]     out_a_q, out_a_d;
    logic [2*W-1:0]     out_b_q, out_b_d;
    logic [LOG2N-2:0]   out_idx_q, out_idx_d;
    logic               out_last_q, out_last_d;
    logic [2*W-1:0]     mem_q [N];
    logic               in_acc;
    logic               out_acc;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // in_ready and out_valid depend only on the state register.
    assign in_ready  = (state_q == S_FILL);
    assign out_valid = (state_q == S_DRAIN);
    assign in_acc    = in_valid & in_ready;
    assign out_acc   = out_valid & out_ready;
    assign rd_nxt    = rd_cnt_q + 1'b1;

    assign out_a    = out_a_q;
    assign out_b    = out_b_q;
    assign out_idx  = out_idx_q;
    assign out_last = out_last_q;

    // Sample storage needs no reset: contents are only read after a full block is written.
    always_ff @(posedge clk) begin
        if (in_acc) begin
            mem_q[wr_cnt_q] <= in_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        out_a_d    = out_a_q;
        out_b_d    = out_b_q;
        out_idx_d  = out_idx_q;
        out_last_d = out_last_q;

        if (state_q == S_FILL) begin
            if (in_acc) begin
                wr_cnt_d = wr_cnt_q + 1'b1;
                if (wr_cnt_q == WR_LAST) begin
                    // Pair 0 is preloaded here; x[N-1] is never part of it, so the
                    // memory already holds both operands.
                    state_d    = S_DRAIN;
                    wr_cnt_d   = '0;
                    rd_cnt_d   = '0;
                    out_a_d    = mem_q[IDX_ZERO];
                    out_b_d    = mem_q[IDX_HALF];
                    out_idx_d  = '0;
                    out_last_d = 1'b0;
                end
            end
        end else begin
            if (out_acc) begin
                if (rd_cnt_q == RD_LAST) begin
                    state_d    = S_FILL;
                    rd_cnt_d   = '0;
                    out_a_d    = '0;
                    out_b_d    = '0;
                    out_idx_d  = '0;
                    out_last_d = 1'b0;
                end else begin
                    rd_cnt_d   = rd_nxt;
                    out_a_d    = mem_q[{1'b0, rd_nxt}];
                    out_b_d    = mem_q[{1'b1, rd_nxt}];
                    out_idx_d  = rd_nxt;
                    out_last_d = (rd_nxt == RD_LAST);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FILL;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            out_a_q    <= '0;
            out_b_q    <= '0;
            out_idx_q  <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            out_a_q    <= out_a_d;
            out_b_q    <= out_b_d;
            out_idx_q  <= out_idx_d;
            out_last_q <= out_last_d;
        end
    end

endmodule

// File: tb/tb_bf_pair_feeder.sv
// Bench for bf_pair_feeder: block-level reference model with a per-cycle compare
// process, directed scenarios with literal expectations, and a butterfly golden check.
module tb_bf_pair_feeder;

  localparam int W = 12;
  localparam int N = 16;
  localparam int LOG2N = 4;
  localparam int HALF = N / 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [2*W-1:0]    in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2*W-1:0]    out_a;
  logic [2*W-1:0]    out_b;
  logic [LOG2N-2:0]  out_idx;
  logic              out_last;
  logic              out_valid;
  logic              out_ready = 1'b0;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;
  bit bfly_on = 1'b0;

  // reference model: block buffer, fill count, current pair
  bit             m_fill = 1'b1;
  int             m_cnt = 0;
  int             m_k = 0;
  logic [2*W-1:0] m_blk [N];

  bf_pair_feeder #(.W(W), .N(N), .LOG2N(LOG2N)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_a(out_a), .out_b(out_b), .out_idx(out_idx),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*W-1:0] xk(input int k);
    logic [11:0] kk;
    logic [11:0] nk;
    kk = 12'(k);
    nk = -kk;
    return {kk, nk};
  endfunction

  // radix-2 butterfly: per component sum and difference with one growth bit
  function automatic logic [2*W+1:0] bfly_sum(input logic [2*W-1:0] a, input logic [2*W-1:0] b);
    logic signed [W:0] re;
    logic signed [W:0] im;
    re = $signed({a[2*W-1], a[2*W-1:W]}) + $signed({b[2*W-1], b[2*W-1:W]});
    im = $signed({a[W-1], a[W-1:0]}) + $signed({b[W-1], b[W-1:0]});
    return {re, im};
  endfunction

  function automatic logic [2*W+1:0] bfly_dif(input logic [2*W-1:0] a, input logic [2*W-1:0] b);
    logic signed [W:0] re;
    logic signed [W:0] im;
    re = $signed({a[2*W-1], a[2*W-1:W]}) - $signed({b[2*W-1], b[2*W-1:W]});
    im = $signed({a[W-1], a[W-1:0]}) - $signed({b[W-1], b[W-1:0]});
    return {re, im};
  endfunction

  // model update: what the block feeder must have done at this edge
  always @(posedge clk) begin
    if (rst) begin
      m_fill <= 1'b1;
      m_cnt <= 0;
      m_k <= 0;
    end else if (m_fill) begin
      if (in_valid) begin
        m_blk[m_cnt] <= in_data;
        if (m_cnt == N - 1) begin
          m_fill <= 1'b0;
          m_cnt <= 0;
          m_k <= 0;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end else if (out_ready) begin
      if (m_k == HALF - 1) m_fill <= 1'b1;
      else m_k <= m_k + 1;
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (chk_on && !rst) begin
      check("in_ready", 32'(in_ready), 32'(m_fill));
      check("out_valid", 32'(out_valid), 32'(!m_fill));
      if (!m_fill) begin
        check("out_a", 32'(out_a), 32'(m_blk[m_k]));
        check("out_b", 32'(out_b), 32'(m_blk[m_k + HALF]));
        check("out_idx", 32'(out_idx), 32'(m_k));
        check("out_last", 32'(out_last), 32'(m_k == HALF - 1));
        if (bfly_on && out_ready) begin
          check("bfly_c1", 32'(bfly_sum(out_a, out_b)), 32'(bfly_sum(m_blk[m_k], m_blk[m_k + HALF])));
          check("bfly_c2", 32'(bfly_dif(out_a, out_b)), 32'(bfly_dif(m_blk[m_k], m_blk[m_k + HALF])));
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_a"}, 32'(out_a), 32'h0);
    check({tag, "_out_b"}, 32'(out_b), 32'h0);
    check({tag, "_out_idx"}, 32'(out_idx), 32'h0);
    check({tag, "_out_last"}, 32'(out_last), 32'h0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'h1);
  endtask

  task automatic send_block_x();
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1;
      in_data = xk(k);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain_steps(input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int sent;
    int guard;

    // reset
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_reset_outputs("rst0");
    chk_on = 1'b1;

    // 1: back-to-back block, pairs on consecutive cycles
    out_ready = 1'b1;
    send_block_x();
    check("s1_valid_t1", 32'(out_valid), 32'h1);
    check("s1_a0", 32'(out_a), 32'h000000);
    check("s1_b0", 32'(out_b), 32'h008FF8);
    for (int k = 0; k < HALF; k++) begin
      check("s1_idx", 32'(out_idx), 32'(k));
      check("s1_last", 32'(out_last), 32'(k == HALF - 1));
      if (k == 3) begin
        check("s1_a3", 32'(out_a), 32'h003FFD);
        check("s1_b3", 32'(out_b), 32'h00BFF5);
      end
      step();
    end
    check("s1_ready_back", 32'(in_ready), 32'h1);
    check("s1_valid_off", 32'(out_valid), 32'h0);

    // 2: stall at pair 2
    send_block_x();
    step();
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("s2_a_hold", 32'(out_a), 32'h002FFE);
      check("s2_b_hold", 32'(out_b), 32'h00AFF6);
      check("s2_idx_hold", 32'(out_idx), 32'h2);
    end
    drain_steps(6);
    check("s2_ready_back", 32'(in_ready), 32'h1);

    // 3: in_valid held high through DRAIN with changing data
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1;
      in_data = xk(k) ^ 24'h5A5A5A;
      step();
    end
    for (int c = 0; c < HALF + N; c++) begin
      in_valid = 1'b1;
      in_data = 24'hA00000 + 24'(c);
      step();
      if (c == 0) check("s3_ready_low", 32'(in_ready), 32'h0);
    end
    in_valid = 1'b0;
    check("s3_a0", 32'(out_a), 32'hA00008);
    check("s3_b0", 32'(out_b), 32'hA00010);
    drain_steps(HALF);

    // 4: random idle gaps in FILL
    sent = 0;
    guard = 0;
    while (sent < N && guard < 500) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = xk(sent);
      step();
      if (in_valid) sent++;
      guard++;
    end
    if (sent < N) fail_now("s4_fill");
    in_valid = 1'b0;
    check("s4_a0", 32'(out_a), 32'h000000);
    drain_steps(HALF);

    // 5: reset mid-FILL, then a fresh block
    for (int k = 0; k < 9; k++) begin
      in_valid = 1'b1;
      in_data = 24'hEEE000 + 24'(k);
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outputs("s5");
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1;
      in_data = 24'h500000 + 24'(k);
      step();
    end
    in_valid = 1'b0;
    check("s5_a0", 32'(out_a), 32'h500000);
    check("s5_b0", 32'(out_b), 32'h500008);
    drain_steps(HALF);

    // 6: random blocks through the butterfly with random handshakes
    bfly_on = 1'b1;
    for (int b = 0; b < 64; b++) begin
      sent = 0;
      guard = 0;
      while (sent < N && guard < 500) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data = 24'($urandom);
        out_ready = 1'($urandom_range(0, 1));
        step();
        if (in_valid) sent++;
        guard++;
      end
      if (sent < N) fail_now("s6_fill");
      in_valid = 1'b0;
      guard = 0;
      while (!m_fill && guard < 500) begin
        out_ready = 1'($urandom_range(0, 1));
        in_valid = 1'($urandom_range(0, 1));
        in_data = 24'($urandom);
        step();
        guard++;
      end
      in_valid = 1'b0;
      if (!m_fill) fail_now("s6_drain");
    end
    bfly_on = 1'b0;
    out_ready = 1'b0;
    step();
    step();

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
